// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one partial product per cycle, signed/unsigned modes.
// Operands are latched as magnitudes plus a sign flag; the sign is applied once at the end.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier_input,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [AW-1:0]        acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [WIDTH-1:0]     addend_d;
  logic [WIDTH:0]       upper_sum_d;
  logic [AW-1:0]        acc_d;
  logic [WIDTH-1:0]     mplier_d;
  logic [2*WIDTH-1:0]   final_d;
  logic [2*WIDTH-1:0]   product_d;
  logic                 last_d;

  // Two's complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // One add-then-shift iteration and the sign-corrected product on the last one
  always_comb begin
    addend_d    = {WIDTH{1'b0}};
    upper_sum_d = {(WIDTH+1){1'b0}};
    acc_d       = {AW{1'b0}};
    mplier_d    = {WIDTH{1'b0}};
    final_d     = {(2*WIDTH){1'b0}};
    product_d   = {(2*WIDTH){1'b0}};
    last_d      = 1'b0;

    if (mplier_q[0]) begin
      addend_d = mcand_q;
    end else begin
      addend_d = {WIDTH{1'b0}};
    end

    // Upper half never exceeds 2^WIDTH-1 before the add, so WIDTH+1 bits hold the sum.
    upper_sum_d = acc_q[AW-1:WIDTH] + {1'b0, addend_d};
    acc_d       = {1'b0, upper_sum_d, acc_q[WIDTH-1:1]};
    mplier_d    = {acc_q[0], mplier_q[WIDTH-1:1]};
    final_d     = acc_d[2*WIDTH-1:0];

    if (neg_q) begin
      product_d = ~final_d + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      product_d = final_d;
    end

    last_d = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM with registered handshake outputs and datapath state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      acc_q       <= {AW{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      neg_q       <= 1'b0;
      product_q   <= {(2*WIDTH){1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q    <= magnitude(multiplicand, signed_mode);
            mplier_q   <= magnitude(multiplier_input, signed_mode);
            neg_q      <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier_input[WIDTH-1]);
            acc_q      <= {AW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (last_d) begin
            product_q   <= product_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule
